// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI master and slave: state encoding,
// SPI mode constants and the byte width.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        GAP,
        HOLD
    } spi_state_e;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;
    localparam int BYTE_W   = 8;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: CLK_DIV down-counter, registered sclk and single-cycle
// strobes marking the clk edges where sclk rises or falls.
module spi_clk_gen
    import aes_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic toggle_en,
    output logic tick,
    output logic rise_stb,
    output logic fall_stb,
    output logic sclk
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick     = en && (cnt == '0);
    assign rise_stb = tick && toggle_en && (sclk == 1'b0);
    assign fall_stb = tick && toggle_en && (sclk == 1'b1);

    // While disabled the counter is preloaded so the first half-period after enable is full length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            sclk <= SPI_CPOL;
        end else if (!en) begin
            cnt  <= RELOAD;
            sclk <= SPI_CPOL;
        end else begin
            cnt <= tick ? RELOAD : cnt - 1'b1;
            if (tick && toggle_en) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/aes_spi_master.sv
// SPI mode-0 initiator shifting a FRAME_BYTES-wide frame out on mosi while capturing miso.
// Optional AES_SPI_MASTER_BYTE_GAP_EN inserts a 2*CLK_DIV sclk-low gap between bytes.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int FRAME_BYTES = 16,
    parameter int CLK_DIV     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BYTE_W*FRAME_BYTES-1:0] tx_frame,
    output logic [BYTE_W*FRAME_BYTES-1:0] rx_frame,
    output logic                          busy,
    output logic                          done,
    output logic                          cs,
    output logic                          sclk,
    output logic                          mosi,
    input  logic                          miso
);

    localparam int BITS_TOTAL = BYTE_W * FRAME_BYTES;
    localparam int BIT_W      = $clog2(BITS_TOTAL + 1);
    localparam int CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(BITS_TOTAL);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_TOTAL - 1);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(CLK_DIV - 1);

    spi_state_e state, next_state;

    logic [BITS_TOTAL-1:0] tx_shift;
    logic [BITS_TOTAL-1:0] rx_shift;
    logic [BIT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      hold_cnt;
    logic                  clk_en;
    logic                  toggle_en;
    logic                  tick;
    logic                  rise_stb;
    logic                  fall_stb;
    logic                  capture_stb;
    logic                  shift_stb;

    assign clk_en      = (state == SETUP) || (state == XFER) || (state == GAP);
    assign toggle_en   = (state == SETUP) || ((state == XFER) && (bit_cnt != BIT_END));
    assign capture_stb = (SPI_CPHA == 1'b0) ? rise_stb : fall_stb;
    assign shift_stb   = (SPI_CPHA == 1'b0) ? fall_stb : rise_stb;
    assign mosi        = tx_shift[BITS_TOTAL-1];

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (clk_en),
        .toggle_en (toggle_en),
        .tick      (tick),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .sclk      (sclk)
    );

`ifdef AES_SPI_MASTER_BYTE_GAP_EN
    logic byte_end;
    logic gap_half;

    // A byte ends on the falling edge of its eighth bit; the final byte goes straight to HOLD.
    assign byte_end = (bit_cnt[2:0] == 3'd7) && (bit_cnt != LAST_BIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_half <= 1'b0;
        end else if ((state == GAP) && tick) begin
            gap_half <= ~gap_half;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // After the last falling edge XFER still waits out one low half-period before HOLD.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    next_state = XFER;
                end
            end
            XFER: begin
                if (tick && (bit_cnt == BIT_END)) begin
                    next_state = HOLD;
                end
`ifdef AES_SPI_MASTER_BYTE_GAP_EN
                else if (shift_stb && byte_end) begin
                    next_state = GAP;
                end
`endif
            end
`ifdef AES_SPI_MASTER_BYTE_GAP_EN
            GAP: begin
                if (tick && gap_half) begin
                    next_state = XFER;
                end
            end
`endif
            HOLD: begin
                if (hold_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The final shift is suppressed so mosi keeps the last bit until the frame closes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_shift <= '0;
            rx_shift <= '0;
            rx_frame <= '0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            cs       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    tx_shift <= tx_frame;
                    bit_cnt  <= '0;
                    cs       <= 1'b0;
                    busy     <= 1'b1;
                end
            end else begin
                if (capture_stb) begin
                    rx_shift <= {rx_shift[BITS_TOTAL-2:0], miso};
                end
                if (shift_stb) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt != LAST_BIT) begin
                        tx_shift <= tx_shift << 1;
                    end
                end
                if ((state == XFER) && (next_state == HOLD)) begin
                    hold_cnt <= RELOAD;
                end else if (state == HOLD) begin
                    if (hold_cnt == '0) begin
                        cs       <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rx_frame <= rx_shift;
                        bit_cnt  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master: a 2-byte/div-2 instance against a behavioural SPI
// slave, plus a 1-byte/div-1 instance for the fastest divider setting.
module tb_aes_spi_master;

    localparam int FB_A = 2;
    localparam int CD_A = 2;
    localparam int FB_B = 1;
    localparam int CD_B = 1;
`ifdef AES_SPI_MASTER_BYTE_GAP_EN
    localparam int GAP_A = (FB_A - 1) * 2 * CD_A;
`else
    localparam int GAP_A = 0;
`endif
    localparam int LAT_A = (16 * FB_A + 2) * CD_A + GAP_A;
    localparam int LAT_B = (16 * FB_B + 2) * CD_B;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] resp;
        logic [15:0] exp_rx;
        logic [15:0] exp_mosi;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_a, busy_a, done_a, cs_a, sclk_a, mosi_a, miso_a;
    logic [15:0] tx_a, rx_a;
    logic        start_b, busy_b, done_b, cs_b, sclk_b, mosi_b, miso_b;
    logic [7:0]  tx_b, rx_b;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 clk = ~clk;

    aes_spi_master #(.FRAME_BYTES(FB_A), .CLK_DIV(CD_A)) dut_a (
        .clk(clk), .reset(reset_n), .start(start_a), .tx_frame(tx_a), .rx_frame(rx_a),
        .busy(busy_a), .done(done_a), .cs(cs_a), .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a)
    );

    aes_spi_master #(.FRAME_BYTES(FB_B), .CLK_DIV(CD_B)) dut_b (
        .clk(clk), .reset(reset_n), .start(start_b), .tx_frame(tx_b), .rx_frame(rx_b),
        .busy(busy_b), .done(done_b), .cs(cs_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
    );

    // Mode-0 slave models: present the next response bit after cs/sclk fall, log mosi on sclk rise.
    logic [15:0] slv_resp_a = '0, slv_shift_a = '0;
    logic [7:0]  slv_resp_b = '0, slv_shift_b = '0;
    logic        loop_a = 1'b0;
    bit          mosi_q_a[$];
    bit          mosi_q_b[$];

    always @(negedge cs_a) slv_shift_a = slv_resp_a;
    always @(negedge sclk_a) if (cs_a == 1'b0) slv_shift_a = slv_shift_a << 1;
    always @(posedge sclk_a) if (cs_a == 1'b0) mosi_q_a.push_back(mosi_a);
    assign miso_a = loop_a ? mosi_a : slv_shift_a[15];

    always @(negedge cs_b) slv_shift_b = slv_resp_b;
    always @(negedge sclk_b) if (cs_b == 1'b0) slv_shift_b = slv_shift_b << 1;
    always @(posedge sclk_b) if (cs_b == 1'b0) mosi_q_b.push_back(mosi_b);
    assign miso_b = slv_shift_b[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] tx, input logic [15:0] resp, input bit mid_start,
                                 output int latency, output int cs_low, output int dones,
                                 output int busy_err, output logic [15:0] mosi_word, output int n_bits);
        mosi_q_a.delete();
        slv_resp_a = resp;
        @(negedge clk);
        tx_a    = tx;
        start_a = 1'b1;
        @(posedge clk);
        latency  = -1;
        cs_low   = 0;
        dones    = 0;
        busy_err = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start_a = 1'b0;
                tx_a    = ~tx;
            end
            if (mid_start && k == 20) begin
                tx_a    = 16'hFFFF;
                start_a = 1'b1;
            end
            if (mid_start && k == 21) start_a = 1'b0;
            if (cs_a == 1'b0) cs_low++;
            if (done_a == 1'b1) begin
                dones++;
                if (latency < 0) latency = k;
            end
            if (latency < 0 && busy_a !== 1'b1) busy_err++;
            if (latency == k && busy_a !== 1'b0) busy_err++;
            if (latency >= 0 && k >= latency + 6) break;
        end
        n_bits    = mosi_q_a.size();
        mosi_word = '0;
        for (int i = 0; i < 16 && i < n_bits; i++) mosi_word = {mosi_word[14:0], mosi_q_a[i]};
    endtask

    task automatic runAndCheck(input string tag, input logic [15:0] tx, input logic [15:0] resp,
                               input logic [15:0] exp_rx, input logic [15:0] exp_mosi, input bit mid_start);
        int latency, cs_low, dones, busy_err, n_bits;
        logic [15:0] mosi_word;
        applyStimulus(tx, resp, mid_start, latency, cs_low, dones, busy_err, mosi_word, n_bits);
        checkOutput({tag, "_rx"}, 32'(rx_a), 32'(exp_rx));
        checkOutput({tag, "_mosi"}, 32'(mosi_word), 32'(exp_mosi));
        checkOutput({tag, "_nbits"}, 32'(n_bits), 32'd16);
        checkOutput({tag, "_latency"}, 32'(latency), 32'(LAT_A));
        checkOutput({tag, "_cs_low"}, 32'(cs_low), 32'(LAT_A));
        checkOutput({tag, "_dones"}, 32'(dones), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy_err), 32'd0);
    endtask

    initial begin
        vec_t        vecs[4];
        logic [15:0] b2b_rx[2];
        logic [15:0] r_tx, r_resp;
        logic [7:0]  word_b;
        int          waited, dones, n_done, cs_gap, latency, toggles;
        logic        prev_sclk, first_hi;

        vecs[0] = '{16'hA55A, 16'h3CC3, 16'h3CC3, 16'hA55A};
        vecs[1] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
        vecs[2] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[3] = '{16'h8001, 16'h7FFE, 16'h7FFE, 16'h8001};

        reset_n = 1'b0;
        start_a = 1'b0;
        tx_a    = '0;
        start_b = 1'b0;
        tx_b    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cs", 32'(cs_a), 32'd1);
        checkOutput("reset_sclk", 32'(sclk_a), 32'd0);
        checkOutput("reset_mosi", 32'(mosi_a), 32'd0);
        checkOutput("reset_busy", 32'(busy_a), 32'd0);
        checkOutput("reset_done", 32'(done_a), 32'd0);
        checkOutput("reset_rx", 32'(rx_a), 32'd0);
        checkOutput("reset_b_cs", 32'(cs_b), 32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            runAndCheck($sformatf("vec%0d", v), vecs[v].tx, vecs[v].resp, vecs[v].exp_rx, vecs[v].exp_mosi, 1'b0);
        end

        runAndCheck("busy_start", 16'hA55A, 16'h3CC3, 16'h3CC3, 16'hA55A, 1'b1);

        // Abort a frame after its 5th sclk rise.
        mosi_q_a.delete();
        slv_resp_a = 16'h9999;
        @(negedge clk);
        tx_a    = 16'hBEEF;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        waited  = 0;
        while (mosi_q_a.size() < 5 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rst_mid_reached", 32'(waited < 200), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_cs", 32'(cs_a), 32'd1);
        checkOutput("rst_mid_sclk", 32'(sclk_a), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_mid_rx", 32'(rx_a), 32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a == 1'b1) dones++;
        end
        reset_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done_a == 1'b1) dones++;
        end
        checkOutput("rst_mid_no_done", 32'(dones), 32'd0);
        runAndCheck("after_rst", 16'h0001, 16'hC001, 16'hC001, 16'h0001, 1'b0);

        // Back-to-back frames with start held high and a loopback slave.
        loop_a = 1'b1;
        @(negedge clk);
        tx_a    = 16'h1234;
        start_a = 1'b1;
        @(posedge clk);
        n_done = 0;
        cs_gap = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (k == 0) tx_a = 16'h5678;
            if (done_a == 1'b1) begin
                b2b_rx[n_done] = rx_a;
                n_done++;
                if (n_done == 2) begin
                    start_a = 1'b0;
                    break;
                end
            end
            if (n_done == 1 && cs_a == 1'b1) cs_gap++;
        end
        loop_a = 1'b0;
        checkOutput("b2b_dones", 32'(n_done), 32'd2);
        checkOutput("b2b_cs_gap", 32'(cs_gap >= 1), 32'd1);
        checkOutput("b2b_rx0", 32'(b2b_rx[0]), 32'h1234);
        checkOutput("b2b_rx1", 32'(b2b_rx[1]), 32'h5678);
        repeat (4) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            r_tx   = 16'($urandom);
            r_resp = 16'($urandom);
            runAndCheck($sformatf("rand%0d", r), r_tx, r_resp, r_resp, r_tx, 1'b0);
        end

        // Fastest divider on the single-byte instance.
        mosi_q_b.delete();
        slv_resp_b = 8'hC3;
        @(negedge clk);
        tx_b    = 8'h81;
        start_b = 1'b1;
        @(posedge clk);
        latency   = -1;
        toggles   = 0;
        prev_sclk = 1'b0;
        first_hi  = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) start_b = 1'b0;
            if (k == 1) first_hi = sclk_b;
            if (k >= 2 && k <= 16 && sclk_b !== prev_sclk) toggles++;
            prev_sclk = sclk_b;
            if (done_b == 1'b1) begin
                latency = k;
                break;
            end
        end
        word_b = '0;
        for (int i = 0; i < 8 && i < mosi_q_b.size(); i++) word_b = {word_b[6:0], mosi_q_b[i]};
        checkOutput("div1_latency", 32'(latency), 32'(LAT_B));
        checkOutput("div1_rx", 32'(rx_b), 32'hC3);
        checkOutput("div1_mosi", 32'(word_b), 32'h81);
        checkOutput("div1_nbits", 32'(mosi_q_b.size()), 32'd8);
        checkOutput("div1_first_rise", 32'(first_hi), 32'd1);
        checkOutput("div1_toggles", 32'(toggles), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
